// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: valid/ready handshake over a DEPTH-entry FIFO
// with synchronous flush, NOP output when empty, and saturating stall/flush counters.

module pipe_stage_buf #(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_DATA = 32'h00000013,
  parameter int          CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_DATA);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [CW-1:0]     count_r, count_nxt_s;
  logic [PW-1:0]     rd_ptr_r, rd_nxt_s, wr_ptr_r, wr_nxt_s;
  logic              in_ready_r, out_valid_r;
  logic [DATA_W-1:0] out_data_r, head_nxt_s;
  logic [CNT_W-1:0]  stall_cnt_r, stall_nxt_s, flush_cnt_r, flush_nxt_s;
  logic              push_s, pop_s;

  // Explicit wrap keeps non-power-of-2 depths inside the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}}) begin
      return c;
    end else begin
      return c + CNT_W'(1);
    end
  endfunction

  assign push_s = in_valid & in_ready_r & ~flush;
  assign pop_s  = out_valid_r & out_ready & ~flush;

  // Next occupancy and pointers; flush overrides any transfer this cycle.
  always_comb begin
    count_nxt_s = count_r;
    rd_nxt_s    = rd_ptr_r;
    wr_nxt_s    = wr_ptr_r;
    if (flush) begin
      count_nxt_s = {CW{1'b0}};
      rd_nxt_s    = {PW{1'b0}};
      wr_nxt_s    = {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_nxt_s = ptr_inc(wr_ptr_r);
      end else begin
        wr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_nxt_s = ptr_inc(rd_ptr_r);
      end else begin
        rd_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Next head word: a push landing at the new read slot is forwarded directly.
  always_comb begin
    head_nxt_s = NOP_W;
    if (count_nxt_s == {CW{1'b0}}) begin
      head_nxt_s = NOP_W;
    end else if (push_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = in_data;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Statistics counters; both hold at all-ones rather than wrapping.
  always_comb begin
    stall_nxt_s = stall_cnt_r;
    flush_nxt_s = flush_cnt_r;
    if (in_valid && !in_ready_r && !flush) begin
      stall_nxt_s = sat_inc(stall_cnt_r);
    end else begin
      stall_nxt_s = stall_cnt_r;
    end
    if (flush && (count_r != {CW{1'b0}})) begin
      flush_nxt_s = sat_inc(flush_cnt_r);
    end else begin
      flush_nxt_s = flush_cnt_r;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= {CW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= NOP_W;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      count_r     <= count_nxt_s;
      rd_ptr_r    <= rd_nxt_s;
      wr_ptr_r    <= wr_nxt_s;
      in_ready_r  <= (count_nxt_s < CW'(DEPTH));
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
      out_data_r  <= head_nxt_s;
      stall_cnt_r <= stall_nxt_s;
      flush_cnt_r <= flush_nxt_s;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign count     = count_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  pipe_stage_buf_chk #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NOP_W  (NOP_W)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_ready  (in_ready_r),
    .out_valid (out_valid_r),
    .out_data  (out_data_r),
    .count     (count_r)
  );

endmodule

module pipe_stage_buf_chk #(
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 2,
  parameter logic [DATA_W-1:0] NOP_W  = '0
) (
  input logic                       clk,
  input logic                       rst_n,
  input logic                       flush,
  input logic                       in_ready,
  input logic                       out_valid,
  input logic [DATA_W-1:0]          out_data,
  input logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));
  a_full_blocks: assert property (@(posedge clk) disable iff (!rst_n)
    (count == CW'(DEPTH)) |-> !in_ready);
  a_valid_occ: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid == (count != {CW{1'b0}}));
  a_empty_nop: assert property (@(posedge clk) disable iff (!rst_n)
    !out_valid |-> (out_data == NOP_W));
  a_flush_empties: assert property (@(posedge clk) disable iff (!rst_n)
    flush |=> (count == {CW{1'b0}}));

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised elastic pipeline-stage register, the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. Those registers only have a plain enable. This block replaces the enable with a valid/ready handshake and adds a DEPTH-entry skid buffer, a synchronous flush (branch kill) and NOP insertion when empty. It also exports occupancy and stall/flush statistics counters. It sits between any two pipeline stages and carries an opaque DATA_W-bit payload (IR, PC, NPC and control fields concatenated by the instantiating stage).

Parameters:
DATA_W, 32, payload width in bits (>=1)
DEPTH, 2, buffer entries (>=2; non-power-of-2 allowed)
NOP_DATA, 32'h00000013 zero-extended/truncated to DATA_W, value driven on out_data when empty
CNT_W, 16, width of statistics counters (>=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  upstream offers in_data
in_ready  out  1  buffer can accept this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head this cycle
out_data  out  DATA_W  head payload, or NOP_DATA when empty
flush  in  1  synchronous kill of all contents and of this cycle's input
count  out  $clog2(DEPTH+1)  current occupancy
stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0, saturating
flush_cnt  out  CNT_W  flush cycles that discarded at least one entry, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - count=0, rd/wr pointers=0, out_valid=0, out_data=NOP_DATA, stall_cnt=0, flush_cnt=0.
  - in_ready is forced 0 while rst_n=0 and returns to 1 on the first cycle after deassertion.
  - Reset mid-transfer discards all contents; no partial entry survives.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count < DEPTH), derived from registered state only. There is no combinational path from out_ready or in_valid to in_ready.
- out_valid = (count != 0); out_data = mem[rd_ptr] when count != 0, else NOP_DATA. Both are driven from registers and memory only, with no path from in_* inputs.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N (one cycle), provided it is at the head.
- Ordering is strict FIFO. Pointers advance modulo DEPTH: an index equal to DEPTH-1 wraps to 0, which is required for non-power-of-2 DEPTH.
- Simultaneous push and pop: count is unchanged and both pointers advance. With DEPTH=2 and out_ready held 1, count stays at 1 and throughput is one word per cycle.
- Full (count=DEPTH): in_ready=0, so no push. A pop in the same cycle does not enable a push; in_ready rises on the following cycle.
- Empty: pop is impossible (out_valid=0). out_ready is ignored.
- Flush=1 at an edge:
  - count<=0 and rd_ptr<=wr_ptr<=0.
  - The input in that cycle is dropped even if in_valid&in_ready.
  - The head is not considered consumed.
  - The next cycle shows out_valid=0 and out_data=NOP_DATA.
  - flush_cnt increments only if count != 0 before the edge.
  - Flush has priority over push and pop.
- stall_cnt increments on every edge where in_valid=1, in_ready=0 and flush=0. It saturates at 2^CNT_W-1, and flush_cnt saturates the same way. Neither counter wraps.
- Memory contents need no reset; only the count, pointers and counters are reset.

Test Plan:
- Reset: DEPTH=2; hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, out_data=32'h00000013, count=0, counters=0. Release -> in_ready=1 on the next cycle.
- Streaming: out_ready=1; push 0x100..0x107 on consecutive cycles -> out_data is 0x100..0x107 one cycle after each push, in order. count stays 1 and stall_cnt stays 0.
- Backpressure: out_ready=0; push A, B, then hold C with in_valid=1 for 3 cycles -> count=2, in_ready=0, stall_cnt=3. Raise out_ready -> A, B, C delivered in order.
- Flush: buffer full (A, B), flush=1 while in_valid=1 with D -> next cycle count=0, out_valid=0, out_data=NOP_DATA, D absent, flush_cnt=1. Flush while empty -> flush_cnt unchanged.
- Wrap-around: DEPTH=3; 50 random words with random in_valid/out_ready -> output sequence equals input sequence, count never exceeds 3, and in_ready=0 exactly when count=3.
- Reset mid-operation and saturation: assert rst_n=0 with count=2 -> all outputs return to reset values immediately. With CNT_W=4, stall for 20 cycles -> stall_cnt=15 and holds there.
